// File: rtl/cmd_pkg.sv
// Shared definitions for the command front-end: frame constants, parser
// state encoding and the 8-bit additive checksum used on both directions.
package cmd_pkg;

  localparam logic [7:0] HEAD_CMD_DEF = 8'hAA;
  localparam logic [7:0] HEAD_ACK_DEF = 8'h55;
  localparam int         FRAME_LEN    = 6;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV,
    ST_MOD,
    ST_ADDR,
    ST_DATA,
    ST_SUM,
    ST_EXEC,
    ST_WAIT,
    ST_TX
  } state_t;

  function automatic logic [7:0] cksum8(input logic [7:0] a,
                                        input logic [7:0] b,
                                        input logic [7:0] c,
                                        input logic [7:0] d);
    return a + b + c + d;
  endfunction

endpackage

// File: rtl/cmd_ack_ser.sv
// Six-byte acknowledge serializer: captures one reply on load and presents
// it byte by byte over a valid/ready interface.
module cmd_ack_ser
  import cmd_pkg::*;
#(
  parameter logic [7:0] HEAD_ACK = HEAD_ACK_DEF
) (
  input  logic       clk_sys,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] dev,
  input  logic [7:0] mod,
  input  logic [7:0] addr,
  input  logic [7:0] q,
  input  logic       tx_rdy,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

  logic [2:0] idx;
  logic [7:0] dev_r, mod_r, addr_r, q_r, sum_r;

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      busy   <= 1'b0;
      idx    <= 3'd0;
      dev_r  <= 8'h00;
      mod_r  <= 8'h00;
      addr_r <= 8'h00;
      q_r    <= 8'h00;
      sum_r  <= 8'h00;
    end else if (load && !busy) begin
      busy   <= 1'b1;
      idx    <= 3'd0;
      dev_r  <= dev;
      mod_r  <= mod;
      addr_r <= addr;
      q_r    <= q;
      sum_r  <= cksum8(dev, mod, addr, q);
    end else if (busy && tx_rdy) begin
      if (idx == LAST_IDX) begin
        busy <= 1'b0;
        idx  <= 3'd0;
      end else begin
        idx <= idx + 3'd1;
      end
    end
  end

  // Output is forced to zero when idle so the link never sees stale bytes.
  always_comb begin
    tx_data = 8'h00;
    if (busy) begin
      case (idx)
        3'd0:    tx_data = HEAD_ACK;
        3'd1:    tx_data = dev_r;
        3'd2:    tx_data = mod_r;
        3'd3:    tx_data = addr_r;
        3'd4:    tx_data = q_r;
        3'd5:    tx_data = sum_r;
        default: tx_data = 8'h00;
      endcase
    end
  end

  assign done = busy && tx_rdy && (idx == LAST_IDX);

endmodule

// File: rtl/cmd_parser.sv
// Command front-end: parses framed host commands, strobes them into the
// command factory and returns the sampled reply as an acknowledge frame.
module cmd_parser
  import cmd_pkg::*;
#(
  parameter logic [7:0] HEAD_CMD = HEAD_CMD_DEF,
  parameter logic [7:0] HEAD_ACK = HEAD_ACK_DEF,
  parameter int         Q_LAT    = 2,
  parameter int         TOUT     = 50000
) (
  input  logic       clk_sys,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_vld,
  output logic [7:0] tx_data,
  output logic       tx_vld,
  input  logic       tx_rdy,
  output logic [7:0] cmd_dev,
  output logic [7:0] cmd_mod,
  output logic [7:0] cmd_addr,
  output logic [7:0] cmd_data,
  output logic       cmd_vld,
  input  logic [7:0] cmd_q,
  output logic       err_chk,
  output logic       err_tout,
  output logic       err_ovr
);

  localparam logic [15:0] GAP_TC = 16'(TOUT - 1);
  localparam logic [3:0]  LAT_LD = 4'(Q_LAT - 1);

  state_t      state, state_nxt;
  logic [7:0]  dev_r, mod_r, addr_r, data_r;
  logic [15:0] gap_cnt;
  logic [3:0]  lat_cnt;
  logic        in_frame, busy_st, gap_tc, sum_ok, ack_load;
  logic        ack_busy, ack_done;

  assign in_frame = state inside {ST_DEV, ST_MOD, ST_ADDR, ST_DATA, ST_SUM};
  assign busy_st  = state inside {ST_EXEC, ST_WAIT, ST_TX};
  // A byte arriving on the terminal count wins over the timeout.
  assign gap_tc   = in_frame && !rx_vld && (gap_cnt == GAP_TC);
  assign sum_ok   = (rx_data == cksum8(dev_r, mod_r, addr_r, data_r));
  assign ack_load = (state == ST_WAIT) && (lat_cnt == 4'd0);
  assign cmd_vld  = (state == ST_EXEC);
  assign tx_vld   = ack_busy;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (rx_vld && rx_data == HEAD_CMD) state_nxt = ST_DEV;
      ST_DEV:  if (rx_vld) state_nxt = ST_MOD;  else if (gap_tc) state_nxt = ST_IDLE;
      ST_MOD:  if (rx_vld) state_nxt = ST_ADDR; else if (gap_tc) state_nxt = ST_IDLE;
      ST_ADDR: if (rx_vld) state_nxt = ST_DATA; else if (gap_tc) state_nxt = ST_IDLE;
      ST_DATA: if (rx_vld) state_nxt = ST_SUM;  else if (gap_tc) state_nxt = ST_IDLE;
      ST_SUM: begin
        if (rx_vld)      state_nxt = sum_ok ? ST_EXEC : ST_IDLE;
        else if (gap_tc) state_nxt = ST_IDLE;
      end
      ST_EXEC: state_nxt = ST_WAIT;
      ST_WAIT: if (lat_cnt == 4'd0) state_nxt = ST_TX;
      ST_TX:   if (ack_done) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state    <= ST_IDLE;
      dev_r    <= 8'h00;
      mod_r    <= 8'h00;
      addr_r   <= 8'h00;
      data_r   <= 8'h00;
      cmd_dev  <= 8'h00;
      cmd_mod  <= 8'h00;
      cmd_addr <= 8'h00;
      cmd_data <= 8'h00;
      gap_cnt  <= 16'd0;
      lat_cnt  <= 4'd0;
      err_chk  <= 1'b0;
      err_tout <= 1'b0;
      err_ovr  <= 1'b0;
    end else begin
      state    <= state_nxt;
      err_chk  <= (state == ST_SUM) && rx_vld && !sum_ok;
      err_tout <= gap_tc;
      err_ovr  <= busy_st && rx_vld;

      if (rx_vld) begin
        case (state)
          ST_DEV:  dev_r  <= rx_data;
          ST_MOD:  mod_r  <= rx_data;
          ST_ADDR: addr_r <= rx_data;
          ST_DATA: data_r <= rx_data;
          default: ;
        endcase
      end

      if (!in_frame || rx_vld || gap_tc) gap_cnt <= 16'd0;
      else                               gap_cnt <= gap_cnt + 16'd1;

      // Factory-facing fields only move on the edge entering EXEC.
      if ((state == ST_SUM) && rx_vld && sum_ok) begin
        cmd_dev  <= dev_r;
        cmd_mod  <= mod_r;
        cmd_addr <= addr_r;
        cmd_data <= data_r;
      end

      if (state == ST_EXEC)                          lat_cnt <= LAT_LD;
      else if ((state == ST_WAIT) && (lat_cnt != 0)) lat_cnt <= lat_cnt - 4'd1;
    end
  end

  cmd_ack_ser #(
    .HEAD_ACK(HEAD_ACK)
  ) u_ack (
    .clk_sys(clk_sys),
    .rst    (rst),
    .load   (ack_load),
    .dev    (cmd_dev),
    .mod    (cmd_mod),
    .addr   (cmd_addr),
    .q      (cmd_q),
    .tx_rdy (tx_rdy),
    .tx_data(tx_data),
    .busy   (ack_busy),
    .done   (ack_done)
  );

endmodule

// File: tb/tb_cmd_parser.sv
// Self-checking bench for cmd_parser: directed frames pin a timestamp-based
// reference model, which then checks every cycle of a randomized byte stream.
module tb_cmd_parser;

  localparam logic [7:0] HC = 8'hAA;
  localparam logic [7:0] HA = 8'h55;
  localparam int         QL = 2;
  localparam int         TO = 20;

  logic       clk_sys = 1'b0;
  logic       rst     = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_vld  = 1'b0;
  logic       tx_rdy  = 1'b1;
  logic [7:0] cmd_q   = 8'h00;
  logic [7:0] tx_data, cmd_dev, cmd_mod, cmd_addr, cmd_data;
  logic       tx_vld, cmd_vld, err_chk, err_tout, err_ovr;

  always #5 clk_sys = ~clk_sys;

  cmd_parser #(.HEAD_CMD(HC), .HEAD_ACK(HA), .Q_LAT(QL), .TOUT(TO)) dut (
    .clk_sys(clk_sys), .rst(rst),
    .rx_data(rx_data), .rx_vld(rx_vld),
    .tx_data(tx_data), .tx_vld(tx_vld), .tx_rdy(tx_rdy),
    .cmd_dev(cmd_dev), .cmd_mod(cmd_mod), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .cmd_vld(cmd_vld), .cmd_q(cmd_q),
    .err_chk(err_chk), .err_tout(err_tout), .err_ovr(err_ovr)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // Reference model: frames tracked as byte queues and absolute cycle stamps.
  int         cyc = 0;
  bit         m_collect = 0;
  logic [7:0] m_frame[$];
  int         m_last = 0;
  bit         m_busy = 0;
  int         m_exec = -1, m_sample = -1, m_start = -1;
  logic [7:0] m_ack[$];
  logic [7:0] m_dev = 0, m_mod = 0, m_addr = 0, m_data = 0;
  bit         m_chk = 0, m_tout = 0, m_ovr = 0;
  logic       exp_tv;
  logic [7:0] exp_tx;

  int         n_cmd, n_chk, n_tout, n_ovr, n_hold, cmd_cyc, tx_first;
  logic [7:0] tx_log[$];
  logic [7:0] mon_dev, mon_mod, mon_addr, mon_data;
  bit         prev_hold = 0;
  logic [7:0] prev_data = 0;

  always @(negedge clk_sys) begin
    exp_tv = m_busy && (cyc >= m_start) && (m_ack.size() != 0);
    exp_tx = exp_tv ? m_ack[0] : 8'h00;
    checkOutput("cmd_vld",  8'(cmd_vld),  8'(m_busy && (cyc == m_exec)));
    checkOutput("cmd_dev",  cmd_dev,  m_dev);
    checkOutput("cmd_mod",  cmd_mod,  m_mod);
    checkOutput("cmd_addr", cmd_addr, m_addr);
    checkOutput("cmd_data", cmd_data, m_data);
    checkOutput("tx_vld",   8'(tx_vld),   8'(exp_tv));
    checkOutput("tx_data",  tx_data,  exp_tx);
    checkOutput("err_chk",  8'(err_chk),  8'(m_chk));
    checkOutput("err_tout", 8'(err_tout), 8'(m_tout));
    checkOutput("err_ovr",  8'(err_ovr),  8'(m_ovr));

    if (cmd_vld) begin
      n_cmd++; cmd_cyc = cyc;
      mon_dev = cmd_dev; mon_mod = cmd_mod; mon_addr = cmd_addr; mon_data = cmd_data;
    end
    if (err_chk)  n_chk++;
    if (err_tout) n_tout++;
    if (err_ovr)  n_ovr++;
    if (tx_vld && tx_rdy) begin
      if (tx_log.size() == 0) tx_first = cyc;
      tx_log.push_back(tx_data);
    end
    if (prev_hold && (!tx_vld || tx_data != prev_data)) n_hold++;
    prev_hold = tx_vld && !tx_rdy && !rst;
    prev_data = tx_data;

    if (rst) begin
      m_collect = 0; m_frame.delete(); m_busy = 0; m_ack.delete();
      m_dev = 0; m_mod = 0; m_addr = 0; m_data = 0;
      m_chk = 0; m_tout = 0; m_ovr = 0;
    end else begin
      m_chk = 0; m_tout = 0; m_ovr = 0;
      if (m_busy) begin
        if (rx_vld) m_ovr = 1;
        if (cyc == m_sample) begin
          m_ack.delete();
          m_ack.push_back(HA);     m_ack.push_back(m_dev);
          m_ack.push_back(m_mod);  m_ack.push_back(m_addr);
          m_ack.push_back(cmd_q);  m_ack.push_back(8'(m_dev + m_mod + m_addr + cmd_q));
        end else if (cyc >= m_start && tx_rdy && m_ack.size() != 0) begin
          void'(m_ack.pop_front());
          if (m_ack.size() == 0) m_busy = 0;
        end
      end else if (m_collect) begin
        if (rx_vld) begin
          m_frame.push_back(rx_data);
          m_last = cyc;
          if (m_frame.size() == 5) begin
            m_collect = 0;
            if (8'(m_frame[0] + m_frame[1] + m_frame[2] + m_frame[3]) == m_frame[4]) begin
              m_busy = 1;
              m_exec = cyc + 1; m_sample = cyc + 1 + QL; m_start = cyc + 2 + QL;
              m_dev = m_frame[0]; m_mod = m_frame[1]; m_addr = m_frame[2]; m_data = m_frame[3];
            end else begin
              m_chk = 1;
            end
          end
        end else if (cyc - m_last >= TO) begin
          m_tout = 1; m_collect = 0;
        end
      end else if (rx_vld && rx_data == HC) begin
        m_collect = 1; m_frame.delete(); m_last = cyc;
      end
    end
    cyc++;
  end

  int  rdy_mode = 0;
  bit  q_fixed  = 1;
  int  sum_cyc  = 0;

  initial forever begin
    @(posedge clk_sys); #1;
    case (rdy_mode)
      0:       tx_rdy = 1'b1;
      1:       tx_rdy = ~tx_rdy;
      default: tx_rdy = 1'($urandom_range(0, 1));
    endcase
    cmd_q = q_fixed ? 8'h3C : 8'($urandom);
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_sys); #1; end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input int gap);
    rx_data = b; rx_vld = 1'b1;
    @(posedge clk_sys); #1;
    rx_vld = 1'b0;
    idle(gap);
  endtask

  task automatic sendFrame(input logic [7:0] d, input logic [7:0] m, input logic [7:0] a,
                           input logic [7:0] x, input logic [7:0] s, input int gap);
    applyStimulus(HC, gap);
    applyStimulus(d, gap);
    applyStimulus(m, gap);
    applyStimulus(a, gap);
    applyStimulus(x, gap);
    sum_cyc = cyc;
    applyStimulus(s, 0);
  endtask

  task automatic resetMon();
    n_cmd = 0; n_chk = 0; n_tout = 0; n_ovr = 0; n_hold = 0;
    tx_log.delete();
  endtask

  task automatic checkAck(input string tag, input logic [7:0] s);
    logic [7:0] e[6];
    e[0] = 8'h55; e[1] = 8'h01; e[2] = 8'h02; e[3] = 8'h10; e[4] = 8'h3C; e[5] = s;
    checkOutput({tag, "_len"}, 8'(tx_log.size()), 8'd6);
    for (int i = 0; i < 6; i++)
      if (i < tx_log.size()) checkOutput($sformatf("%s_b%0d", tag, i), tx_log[i], e[i]);
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    @(posedge clk_sys); #1;
    rst = 1'b0;
  endtask

  initial begin
    idle(3);
    rst = 1'b0;
    checkOutput("rst_tx_vld",  8'(tx_vld),  8'h00);
    checkOutput("rst_cmd_dev", cmd_dev,     8'h00);

    // Reference frame with hand-computed sums.
    resetMon();
    sendFrame(8'h01, 8'h02, 8'h10, 8'h5A, 8'h6D, 0);
    idle(16);
    checkOutput("good_ncmd",  8'(n_cmd), 8'd1);
    checkOutput("good_dev",   mon_dev,   8'h01);
    checkOutput("good_mod",   mon_mod,   8'h02);
    checkOutput("good_addr",  mon_addr,  8'h10);
    checkOutput("good_data",  mon_data,  8'h5A);
    checkOutput("cmd_lat",    8'(cmd_cyc - sum_cyc),  8'd1);
    checkOutput("tx_lat",     8'(tx_first - sum_cyc), 8'(2 + QL));
    checkAck("good", 8'h4F);

    resetMon();
    sendFrame(8'h01, 8'h02, 8'h10, 8'h5A, 8'h6E, 0);
    idle(12);
    checkOutput("bad_nchk", 8'(n_chk), 8'd1);
    checkOutput("bad_ncmd", 8'(n_cmd), 8'd0);
    checkOutput("bad_ntx",  8'(tx_log.size()), 8'd0);
    sendFrame(8'h01, 8'h02, 8'h10, 8'h5A, 8'h6D, 0);
    idle(16);
    checkOutput("bad_next_ncmd", 8'(n_cmd), 8'd1);
    checkAck("bad_next", 8'h4F);

    resetMon();
    applyStimulus(8'h00, 0); applyStimulus(8'h13, 0); applyStimulus(8'hFF, 0);
    sendFrame(8'h01, 8'h02, 8'h10, 8'h5A, 8'h6D, 0);
    idle(16);
    checkOutput("junk_errs", 8'(n_chk + n_tout + n_ovr), 8'd0);
    checkOutput("junk_ncmd", 8'(n_cmd), 8'd1);
    checkAck("junk", 8'h4F);

    resetMon();
    applyStimulus(HC, 0);
    applyStimulus(8'h01, 20);
    idle(4);
    checkOutput("tout_n",    8'(n_tout), 8'd1);
    checkOutput("tout_ncmd", 8'(n_cmd),  8'd0);
    sendFrame(8'h01, 8'h02, 8'h10, 8'h5A, 8'h6D, 0);
    idle(16);
    checkOutput("tout_next_ncmd", 8'(n_cmd), 8'd1);

    // Byte landing exactly on the terminal count must keep the frame alive.
    resetMon();
    sendFrame(8'h01, 8'h02, 8'h10, 8'h5A, 8'h6D, TO - 1);
    idle(16);
    checkOutput("tc_edge_tout", 8'(n_tout), 8'd0);
    checkOutput("tc_edge_ncmd", 8'(n_cmd),  8'd1);

    resetMon();
    rdy_mode = 1;
    sendFrame(8'h01, 8'h02, 8'h10, 8'h5A, 8'h6D, 0);
    idle(5);
    applyStimulus(8'h77, 0);
    idle(25);
    rdy_mode = 0;
    checkAck("toggle", 8'h4F);
    checkOutput("toggle_novr",  8'(n_ovr),  8'd1);
    checkOutput("toggle_nhold", 8'(n_hold), 8'd0);

    resetMon();
    sendFrame(8'h01, 8'h02, 8'h10, 8'h5A, 8'h6D, 0);
    idle(1);
    pulseReset();
    checkOutput("rstwait_tx_vld", 8'(tx_vld), 8'h00);
    checkOutput("rstwait_dev",    cmd_dev,    8'h00);
    idle(15);
    checkOutput("rstwait_ntx", 8'(tx_log.size()), 8'd0);
    resetMon();
    sendFrame(8'h01, 8'h02, 8'h10, 8'h5A, 8'h6D, 0);
    idle(16);
    checkAck("rstwait_next", 8'h4F);

    resetMon();
    sendFrame(8'h01, 8'h02, 8'h10, 8'h5A, 8'h6D, 0);
    idle(5);
    pulseReset();
    checkOutput("rstack_tx_vld", 8'(tx_vld), 8'h00);
    idle(15);
    checkOutput("rstack_ntx", 8'(tx_log.size()), 8'd3);
    resetMon();
    sendFrame(8'h01, 8'h02, 8'h10, 8'h5A, 8'h6D, 0);
    idle(16);
    checkAck("rstack_next", 8'h4F);

    // Randomized stream; the per-cycle model comparison does the checking.
    resetMon();
    rdy_mode = 2;
    q_fixed  = 0;
    for (int f = 0; f < 80; f++) begin
      logic [7:0] fd, fm, fa, fx, fs;
      int         gsel, gap;
      for (int j = 0; j < int'($urandom_range(0, 2)); j++)
        applyStimulus(8'($urandom_range(0, 169)), int'($urandom_range(0, 2)));
      fd = 8'($urandom); fm = 8'($urandom); fa = 8'($urandom); fx = 8'($urandom);
      fs = 8'(fd + fm + fa + fx);
      if ($urandom_range(0, 9) == 0) fs = fs ^ 8'h01;
      gsel = int'($urandom_range(0, 19));
      gap  = (gsel == 0) ? TO : (gsel == 1) ? TO - 1 : int'($urandom_range(0, 2));
      sendFrame(fd, fm, fa, fx, fs, gap);
      if ($urandom_range(0, 29) == 0) begin
        idle(int'($urandom_range(0, 6)));
        pulseReset();
      end
      idle(int'($urandom_range(0, 12)));
    end
    idle(40);
    checkOutput("rand_nhold", 8'(n_hold), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/cmd_parser.md
# cmd_parser

Front-end command stage that assembles framed commands from a byte stream (host link receiver) and drives the all-cmd path (`cmd_dev/mod/addr/data/vld`) of the command factory. It captures the factory's `cmd_q` reply a fixed latency after each command and returns it to the host as a checksummed acknowledge frame over a valid/ready byte output. It sits between the host link byte receiver/transmitter and the command factory, in the `clk_sys` domain.

## Interface
Parameters:
- `HEAD_CMD`, 8'hAA, header byte of an inbound command frame
- `HEAD_ACK`, 8'h55, header byte of an outbound acknowledge frame
- `Q_LAT`, 2, cycles from `cmd_vld` pulse to `cmd_q` sample (1..15)
- `TOUT`, 50000, max inter-byte gap in cycles inside a frame (2..65535)

Ports:
- `clk_sys` in 1: system clock; the block's only clock
- `rst` in 1: reset, synchronous, active-high
- `rx_data` in 8: received byte
- `rx_vld` in 1: one-cycle strobe, `rx_data` valid
- `tx_data` out 8: acknowledge byte
- `tx_vld` out 1: `tx_data` valid
- `tx_rdy` in 1: transmitter accepts byte when `tx_vld && tx_rdy`
- `cmd_dev`, `cmd_mod`, `cmd_addr`, `cmd_data` out 8 each: command fields
- `cmd_vld` out 1: one-cycle command strobe
- `cmd_q` in 8: command reply from factory
- `err_chk` out 1: one-cycle pulse, checksum mismatch
- `err_tout` out 1: one-cycle pulse, inter-byte timeout
- `err_ovr` out 1: one-cycle pulse, byte dropped while busy

## Operation
- Inbound frame: `HEAD_CMD, dev, mod, addr, data, sum`; `sum = (dev+mod+addr+data) mod 256`.
- Outbound frame: `HEAD_ACK, dev, mod, addr, q, sum`; `sum = (dev+mod+addr+q) mod 256`.
- States: IDLE, DEV, MOD, ADDR, DATA, SUM, EXEC, WAIT, TX.
- IDLE: byte == `HEAD_CMD` -> DEV. Any other byte is ignored silently, with no error.
- DEV..DATA: each `rx_vld` stores the field and advances.
- SUM: a matching byte -> EXEC. A mismatching byte pulses `err_chk` -> IDLE, with no `cmd_vld` and no ack.
- EXEC: `cmd_vld`=1 for exactly this cycle -> WAIT. The wait counter loads `Q_LAT-1`.
- WAIT: counts down. At 0, `cmd_q` is latched into the ack buffer -> TX.
- TX: six bytes are presented in order. The index advances on `tx_vld && tx_rdy`. After the 6th accepted byte -> IDLE.
- Timeout: in DEV..SUM the gap counter clears on every `rx_vld` and on entry. If it reaches `TOUT-1` without a byte, `err_tout` pulses and the state -> IDLE. A partial frame is discarded.
- Busy: an `rx_vld` in EXEC/WAIT/TX drops the byte and pulses `err_ovr`. The state is unaffected. A header arriving in TX is not pre-parsed.
- `cmd_dev..cmd_data` are registered. They update only at the EXEC entry edge and hold until the next EXEC, so they are stable for the factory.
- Reset values: all outputs 0, state IDLE, counters 0.

## Timing
- `rx_vld` on the sum byte at cycle N -> `cmd_vld` high in cycle N+1, with fields valid in the same cycle.
- `cmd_q` is sampled on the edge ending cycle N+1+`Q_LAT`. `tx_vld` rises in cycle N+2+`Q_LAT` with `tx_data`=`HEAD_ACK`.
- `tx_data` is stable while `tx_vld && !tx_rdy`. `tx_vld` never drops without acceptance, except on `rst`.
- With `tx_rdy` tied high, the ack occupies 6 consecutive cycles, and IDLE is re-entered the cycle after the last byte.
- An `rx_vld` in the same cycle as the timeout terminal count: the byte wins. The counter clears and there is no `err_tout`.
- Back-to-back frames: a header in the IDLE cycle immediately after TX is accepted.
- `rst` mid-frame or mid-ack: at the next edge all outputs are 0 and the state is IDLE. A partial ack is abandoned.

## Structure
- Shared package `cmd_pkg`: `HEAD_CMD`/`HEAD_ACK` defaults, frame length 6, state encoding, 8-bit checksum function.
- One sub-module `cmd_ack_ser`: 6-byte valid/ready serializer.
  - Load strobe plus dev/mod/addr/q inputs.
  - Computes the checksum internally.
  - Returns `busy`.
- Parser FSM, timeout counter and latency counter stay in `cmd_parser`.

## Test plan
- Good frame AA 01 02 10 5A 6D, `cmd_q`=3C, `tx_rdy`=1:
  - one `cmd_vld` with fields 01/02/10/5A;
  - tx bytes 55 01 02 10 3C 4F.
- Bad checksum AA 01 02 10 5A 6E -> `err_chk` pulse, no `cmd_vld`, no `tx_vld`. A following good frame is processed normally.
- Junk 00 13 FF before a good frame -> no errors, single correct command and ack.
- `TOUT`=20, send AA 01 then 20 idle cycles -> `err_tout` once, state IDLE. The next good frame succeeds.
- `tx_rdy` toggling 1010…, extra byte during TX:
  - `tx_data` holds while not ready;
  - all 6 bytes arrive in order;
  - `err_ovr` pulses once.
- `rst` asserted during WAIT and again mid-ack -> outputs 0 next cycle, no further tx bytes, clean next frame.
